scpu_fetch: RTL



---
 rtl/scpu_pkg.sv | 41 ++++
 rtl/scpu_next_pc.sv | 35 +++
 rtl/scpu_fetch.sv | 117 +++++++++++
 3 files changed

// File: rtl/scpu_pkg.sv
// Shared definitions for the SCPU fetch stage and its controller:
// next-PC selects, fetch FSM states and the opcode/function constants.
package scpu_pkg;

  localparam logic [1:0] BR_SEQ = 2'b00;
  localparam logic [1:0] BR_BEQ = 2'b01;
  localparam logic [1:0] BR_J   = 2'b10;
  localparam logic [1:0] BR_JR  = 2'b11;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUN_SLL  = 6'b000000;
  localparam logic [5:0] FUN_SRL  = 6'b000010;
  localparam logic [5:0] FUN_JR   = 6'b001000;
  localparam logic [5:0] FUN_ADD  = 6'b100000;
  localparam logic [5:0] FUN_SUB  = 6'b100010;
  localparam logic [5:0] FUN_AND  = 6'b100100;
  localparam logic [5:0] FUN_OR   = 6'b100101;
  localparam logic [5:0] FUN_XOR  = 6'b100110;
  localparam logic [5:0] FUN_NOR  = 6'b100111;
  localparam logic [5:0] FUN_SLT  = 6'b101010;

endpackage

// File: rtl/scpu_next_pc.sv
// Combinational next-PC selection for the fetch stage, including the
// jr target alignment check.
module scpu_next_pc
  import scpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] ir_low,
  input  logic [1:0]  branch,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] br_off;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{ir_low[15]}}, ir_low[15:0], 2'b00};

  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    case (branch)
      BR_BEQ: next_pc = pc_plus4 + br_off;
      BR_J:   next_pc = {pc_plus4[31:28], ir_low, 2'b00};
      BR_JR: begin
        // Low bits are dropped from the target but still flagged.
        next_pc  = {rs_data[31:2], 2'b00};
        misalign = |rs_data[1:0];
      end
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/scpu_fetch.sv
// Instruction fetch / PC sequencing for the single-cycle SCPU: one
// request/ready fetch per step, execute hold on data-side stalls.
module scpu_fetch
  import scpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] inst_in,
  output logic [31:0] IR,
  output logic [5:0]  OPcode,
  output logic [5:0]  Fun,
  output logic        inst_valid,
  input  logic [1:0]  Branch,
  input  logic [31:0] rs_data,
  input  logic        MIO_ready,
  input  logic        mem_access,
  output logic [31:0] PC_out,
  output logic [31:0] PC_plus4,
  output logic        retire,
  output logic        fetch_err,
  output logic        misalign
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  fetch_state_t  state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   ir_reg, ir_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          fetch_err_reg, fetch_err_next;
  logic          misalign_reg, misalign_next;

  logic [31:0]   npc;
  logic          npc_misalign;

  scpu_next_pc u_next_pc (
    .pc       (pc_reg),
    .ir_low   (ir_reg[25:0]),
    .branch   (Branch),
    .rs_data  (rs_data),
    .pc_plus4 (PC_plus4),
    .next_pc  (npc),
    .misalign (npc_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RESET;
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      wait_cnt_reg  <= '0;
      fetch_err_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ir_reg        <= ir_next;
      wait_cnt_reg  <= wait_cnt_next;
      fetch_err_reg <= fetch_err_next;
      misalign_reg  <= misalign_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    wait_cnt_next  = wait_cnt_reg;
    fetch_err_next = fetch_err_reg;
    misalign_next  = misalign_reg;
    inst_req       = 1'b0;
    inst_valid     = 1'b0;
    retire         = 1'b0;
    case (state_reg)
      S_RESET: state_next = S_REQ;
      S_REQ: begin
        inst_req = 1'b1;
        if (inst_ready) begin
          ir_next       = inst_in;
          wait_cnt_next = '0;
          state_next    = S_EXEC;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Counter parks at the limit; the request stays up after the timeout.
          fetch_err_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        if (!(mem_access && !MIO_ready)) begin
          pc_next    = npc;
          retire     = 1'b1;
          state_next = S_REQ;
          if (npc_misalign) misalign_next = 1'b1;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  assign inst_addr = pc_reg;
  assign PC_out    = pc_reg;
  assign IR        = ir_reg;
  assign OPcode    = ir_reg[31:26];
  assign Fun       = ir_reg[5:0];
  assign fetch_err = fetch_err_reg;
  assign misalign  = misalign_reg;

endmodule
